// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared constants and state encodings for the iterative divider
//
// Purpose: width of the team prefix adder (INPUTSIZE) and the divider FSM
//          state encoding used by iter_divider and div_sub_step.
// Ports:   none (package).
package iter_divider_pkg;

  // Width of the prefix adder; the divider WIDTH must match it.
  localparam int INPUTSIZE = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - prefix adder configured as an (a - b) subtractor
//
// Purpose: one trial subtract per divider step, a + ~b + 1.
// Ports:   a         in   WIDTH  minuend
//          b         in   WIDTH  subtrahend
//          diff      out  WIDTH  a - b (wraps)
//          carry_out out  1      1 when a >= b (no borrow)
module div_sub_step
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = INPUTSIZE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             carry_out
);

  // B inverted with carry-in of one; the adder's carry-out is the not-borrow flag.
  always_comb begin
    {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
//
// Purpose: divides dividend by divisor over WIDTH restoring steps plus a sign
//          fix-up cycle; divide-by-zero and signed overflow resolve at accept.
// Ports:   clk, rst_n               clock, async active-low reset
//          in_valid/in_ready        operand handshake (ready only in IDLE)
//          dividend, divisor        operands, sampled at accept only
//          is_signed                1 = DIV/REM, 0 = DIVU/REMU
//          flush                    kill in-flight op, back to IDLE
//          out_valid/out_ready      result handshake
//          quotient, remainder      result, stable while out_valid
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = INPUTSIZE,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state, state_n;
  logic             valid_q, valid_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rem_q, rem_n;
  logic [WIDTH-1:0] quo_q, quo_n;
  logic [WIDTH-1:0] dvs_q, dvs_n;
  logic             neg_quo, neg_quo_n;
  logic             neg_rem, neg_rem_n;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             div_zero, sgn_ovf;
  logic [WIDTH-1:0] rem_sh, trial;
  logic             carry, take;

  assign in_ready  = (state == DIV_IDLE);
  assign out_valid = valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign accept    = in_valid && in_ready && !flush;

  assign a_neg    = is_signed && dividend[WIDTH-1];
  assign b_neg    = is_signed && divisor[WIDTH-1];
  assign a_abs    = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_abs    = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign sgn_ovf  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_sub (
    .a         (rem_sh),
    .b         (dvs_q),
    .diff      (trial),
    .carry_out (carry)
  );

  // The shifted remainder really has WIDTH+1 bits. If the bit shifted out was
  // set, the partial remainder is >= 2**WIDTH > divisor, so the subtract
  // always succeeds and the wrapped WIDTH-bit difference is exact.
  assign take = carry || rem_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DIV_IDLE;
      valid_q <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      state   <= state_n;
      valid_q <= valid_n;
      cnt     <= cnt_n;
      rem_q   <= rem_n;
      quo_q   <= quo_n;
      dvs_q   <= dvs_n;
      neg_quo <= neg_quo_n;
      neg_rem <= neg_rem_n;
    end
  end

  always_comb begin
    state_n   = state;
    valid_n   = valid_q;
    cnt_n     = cnt;
    rem_n     = rem_q;
    quo_n     = quo_q;
    dvs_n     = dvs_q;
    neg_quo_n = neg_quo;
    neg_rem_n = neg_rem;

    case (state)
      DIV_IDLE: begin
        if (accept) begin
          neg_quo_n = 1'b0;
          neg_rem_n = 1'b0;
          cnt_n     = '0;
          if (div_zero) begin
            quo_n   = '1;
            rem_n   = dividend;
            state_n = DIV_DONE;
          end else if (sgn_ovf) begin
            quo_n   = dividend;
            rem_n   = '0;
            state_n = DIV_DONE;
          end else begin
            quo_n     = a_abs;
            rem_n     = '0;
            dvs_n     = b_abs;
            neg_quo_n = a_neg ^ b_neg;
            neg_rem_n = a_neg;
            state_n   = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_n = take ? trial : rem_sh;
        quo_n = {quo_q[WIDTH-2:0], take};
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n = DIV_FIX;
        end
      end
      DIV_FIX: begin
        quo_n   = neg_quo ? (~quo_q + 1'b1) : quo_q;
        rem_n   = neg_rem ? (~rem_q + 1'b1) : rem_q;
        state_n = DIV_DONE;
      end
      DIV_DONE: begin
        // out_valid is registered: it rises on the cycle after DONE is entered.
        if (!valid_q) begin
          valid_n = 1'b1;
        end else if (out_ready) begin
          valid_n = 1'b0;
          state_n = DIV_IDLE;
        end
      end
      default: state_n = DIV_IDLE;
    endcase

    if (flush) begin
      state_n = DIV_IDLE;
      valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - directed self-checking bench for iter_divider
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iter_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [31:0] q, output logic [31:0] r);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h1234_5678;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%h r=%h, expected 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int lat;
    logic [31:0] q, r;
    run_op(32'd100, 32'd7, 1'b0, lat, q, r);
    vectors++;
    if (lat !== 34 || q !== 32'd14 || r !== 32'd2) begin
      miscompares++;
      $display("FAIL unsigned_100_7: lat=%0d q=%h r=%h, expected 34 0000000e 00000002", lat, q, r);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handshake_done: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed;
    int lat;
    logic [31:0] q, r;
    run_op(32'hFFFF_FFF9, 32'h2, 1'b1, lat, q, r);
    vectors++;
    if (lat !== 34 || q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL signed_m7_2: lat=%0d q=%h r=%h, expected 34 fffffffd ffffffff", lat, q, r);
    end
    @(posedge clk); #1;
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, q, r);
    vectors++;
    if (lat !== 34 || q !== 32'hFFFF_FFFD || r !== 32'h1) begin
      miscompares++;
      $display("FAIL signed_7_m2: lat=%0d q=%h r=%h, expected 34 fffffffd 00000001", lat, q, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat;
    logic [31:0] q, r;
    for (int s = 0; s < 2; s++) begin
      run_op(32'd5, 32'd0, s[0], lat, q, r);
      vectors++;
      if (lat !== 1 || q !== 32'hFFFF_FFFF || r !== 32'd5) begin
        miscompares++;
        $display("FAIL div_zero signed=%0d: lat=%0d q=%h r=%h, expected 1 ffffffff 00000005", s, lat, q, r);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow;
    int lat;
    logic [31:0] q, r;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, q, r);
    vectors++;
    if (lat !== 1 || q !== 32'h8000_0000 || r !== 32'h0) begin
      miscompares++;
      $display("FAIL overflow_signed: lat=%0d q=%h r=%h, expected 1 80000000 00000000", lat, q, r);
    end
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, q, r);
    vectors++;
    if (lat !== 34 || q !== 32'h0 || r !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL overflow_unsigned: lat=%0d q=%h r=%h, expected 34 00000000 80000000", lat, q, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    logic [31:0] q, r;
    out_ready = 1'b0;
    // 0xFFFFFFFF / 0x80000001 exercises the shifted-out remainder bit.
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, lat, q, r);
    vectors++;
    if (lat !== 34 || q !== 32'h1 || r !== 32'h7FFF_FFFE) begin
      miscompares++;
      $display("FAIL bp_result: lat=%0d q=%h r=%h, expected 34 00000001 7ffffffe", lat, q, r);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'h1 || remainder !== 32'h7FFF_FFFE)
        bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush;
    int highs;
    // flush beats a same-cycle accept in IDLE
    dividend  = 32'd9;
    divisor   = 32'd3;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_idle_accept: in_ready=%b, expected 1", in_ready);
    end
    // flush at RUN step 10
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_run: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) highs++;
    end
    vectors++;
    if (highs !== 0) begin
      miscompares++;
      $display("FAIL flush_no_result: out_valid high %0d cycles, expected 0", highs);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic [31:0] q, r;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b q=%h r=%h, expected 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, lat, q, r);
    vectors++;
    if (lat !== 34 || q !== 32'h0FFF_FFFF || r !== 32'hF) begin
      miscompares++;
      $display("FAIL after_reset_op: lat=%0d q=%h r=%h, expected 34 0fffffff 0000000f", lat, q, r);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
    is_signed = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_backpressure;
    test_flush;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
